// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave
// Brief    : 7-bit addressed I2C slave with a 4-register CPU bus port.
//            Optional clock stretching: define I2C_SLAVE_CLKSTRETCH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic [1:0]  adr_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] dat_i,
   output logic [31:0] dat_o,
   output logic        ack_o,
   input  logic        scl_i,
   input  logic        sda_i,
   output logic        sda_oe,
   output logic        scl_oe
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ADDR     = 3'd1,
      S_ADDR_ACK = 3'd2,
      S_RX       = 3'd3,
      S_RX_ACK   = 3'd4,
      S_TX       = 3'd5,
      S_TX_ACK   = 3'd6,
      S_IGNORE   = 3'd7
   } state_t;

   localparam logic [7:0] C_TX_IDLE_BYTE = 8'hFF;

   logic r_scl_s1, r_scl_s2, r_scl_d;
   logic r_sda_s1, r_sda_s2, r_sda_d;

   state_t     r_state, w_state_nxt;
   logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0] r_shift, w_shift_nxt;
   logic       r_rw, w_rw_nxt;
   logic       r_phase, w_phase_nxt;
   logic       r_ack_byte, w_ack_byte_nxt;
   logic       r_tx_load, w_tx_load_nxt;
   logic       r_rx_pend, w_rx_pend_nxt;
   logic       r_sda_oe, w_sda_oe_nxt;
   logic       r_scl_oe, w_scl_oe_nxt;
   logic [7:0] r_rx_data, w_rx_data_nxt;

   logic [7:0] r_tx_data;
   logic       r_rx_full, r_tx_empty, r_overrun, r_nak_rx, r_busy;
   logic       w_rx_full_set, w_tx_empty_set, w_overrun_set, w_nak_set, w_busy_set;
   logic       w_tx_req;

   logic        r_ack;
   logic [31:0] r_dat, w_rd_data;
   logic        w_req, w_wr0, w_wr1, w_rd0;

   logic       w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [7:0] w_rx_byte, w_tx_byte;
   logic       w_unused;

   // Line synchronizers; the third flop gives the previous sample for edge detect
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_d <= 1'b1;
         r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_d <= 1'b1;
      end else begin
         r_scl_s1 <= scl_i; r_scl_s2 <= r_scl_s1; r_scl_d <= r_scl_s2;
         r_sda_s1 <= sda_i; r_sda_s2 <= r_sda_s1; r_sda_d <= r_sda_s2;
      end
   end

   assign w_scl_rise = r_scl_s2 & ~r_scl_d;
   assign w_scl_fall = ~r_scl_s2 & r_scl_d;
   assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
   assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
   assign w_rx_byte  = {r_shift[6:0], r_sda_s2};
   assign w_tx_byte  = r_tx_empty ? C_TX_IDLE_BYTE : r_tx_data;

   assign w_req = cyc_i & stb_i & ~r_ack;
   assign w_wr0 = w_req & we_i & (adr_i == 2'd0) & sel_i[0];
   assign w_wr1 = w_req & we_i & (adr_i == 2'd1) & sel_i[0];
   assign w_rd0 = w_req & ~we_i & (adr_i == 2'd0);

   always_comb begin
      w_rd_data = 32'h0;
      case (adr_i)
         2'd0:    w_rd_data = {24'h0, r_rx_data};
         2'd1:    w_rd_data = {27'h0, r_nak_rx, r_overrun, r_busy, r_tx_empty, r_rx_full};
         default: w_rd_data = 32'h0;
      endcase
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_shift_nxt    = r_shift;
      w_rw_nxt       = r_rw;
      w_phase_nxt    = r_phase;
      w_ack_byte_nxt = r_ack_byte;
      w_tx_load_nxt  = r_tx_load;
      w_rx_pend_nxt  = r_rx_pend;
      w_sda_oe_nxt   = r_sda_oe;
      w_scl_oe_nxt   = r_scl_oe;
      w_rx_data_nxt  = r_rx_data;
      w_rx_full_set  = 1'b0;
      w_tx_empty_set = 1'b0;
      w_overrun_set  = 1'b0;
      w_nak_set      = 1'b0;
      w_busy_set     = 1'b0;
      w_tx_req       = 1'b0;

      if (w_start || w_stop) begin
         w_state_nxt   = w_start ? S_ADDR : S_IDLE;
         w_bit_cnt_nxt = 3'd7;
         w_shift_nxt   = 8'h00;
         w_phase_nxt   = 1'b0;
         w_tx_load_nxt = 1'b0;
         w_rx_pend_nxt = 1'b0;
         w_sda_oe_nxt  = 1'b0;
         w_scl_oe_nxt  = 1'b0;
      end else begin
         case (r_state)
            S_ADDR: begin
               if (w_scl_rise) begin
                  w_shift_nxt   = w_rx_byte;
                  w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                  if (r_bit_cnt == 3'd0) begin
                     w_phase_nxt = 1'b0;
                     if (w_rx_byte[7:1] == SLAVE_ADDR) begin
                        w_state_nxt = S_ADDR_ACK;
                        w_rw_nxt    = w_rx_byte[0];
                     end else begin
                        w_state_nxt = S_IGNORE;
                     end
                  end
               end
            end
            S_ADDR_ACK: begin
               if (w_scl_fall && !r_phase) begin
                  w_sda_oe_nxt = 1'b1;
                  w_busy_set   = 1'b1;
                  w_phase_nxt  = 1'b1;
               end else if (w_scl_fall) begin
                  w_sda_oe_nxt = 1'b0;
                  w_phase_nxt  = 1'b0;
                  if (r_rw) begin
                     w_state_nxt   = S_TX;
                     w_tx_load_nxt = 1'b1;
                     w_tx_req      = 1'b1;
                  end else begin
                     w_state_nxt   = S_RX;
                     w_bit_cnt_nxt = 3'd7;
                     w_shift_nxt   = 8'h00;
                  end
               end
            end
            S_RX: begin
               if (w_scl_rise) begin
                  w_shift_nxt   = w_rx_byte;
                  w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                  if (r_bit_cnt == 3'd0) begin
                     w_state_nxt = S_RX_ACK;
                     w_phase_nxt = 1'b0;
                     if (!r_rx_full) begin
                        w_rx_data_nxt  = w_rx_byte;
                        w_rx_full_set  = 1'b1;
                        w_ack_byte_nxt = 1'b1;
                     end else begin
`ifdef I2C_SLAVE_CLKSTRETCH_EN
                        w_rx_pend_nxt  = 1'b1;
                        w_ack_byte_nxt = 1'b1;
`else
                        w_overrun_set  = 1'b1;
                        w_ack_byte_nxt = 1'b0;
`endif
                     end
                  end
               end
            end
            S_RX_ACK: begin
               if (!r_phase) begin
                  // a held byte is committed as soon as the CPU frees rx_data
                  if (w_scl_fall || r_scl_oe) begin
                     if (r_rx_pend) begin
                        if (r_rx_full) begin
                           w_scl_oe_nxt = 1'b1;
                        end else begin
                           w_rx_data_nxt = r_shift;
                           w_rx_full_set = 1'b1;
                           w_rx_pend_nxt = 1'b0;
                           w_scl_oe_nxt  = 1'b0;
                           w_sda_oe_nxt  = 1'b1;
                           w_phase_nxt   = 1'b1;
                        end
                     end else begin
                        w_sda_oe_nxt = r_ack_byte;
                        w_phase_nxt  = 1'b1;
                     end
                  end
               end else if (w_scl_fall) begin
                  w_sda_oe_nxt  = 1'b0;
                  w_phase_nxt   = 1'b0;
                  w_state_nxt   = S_RX;
                  w_bit_cnt_nxt = 3'd7;
                  w_shift_nxt   = 8'h00;
               end
            end
            S_TX: begin
               if (r_tx_load) begin
                  w_tx_req = w_scl_fall | r_scl_oe;
               end else if (w_scl_fall) begin
                  if (r_bit_cnt != 3'd0) begin
                     w_sda_oe_nxt  = ~r_shift[7];
                     w_shift_nxt   = {r_shift[6:0], 1'b1};
                     w_bit_cnt_nxt = r_bit_cnt - 3'd1;
                  end else begin
                     w_sda_oe_nxt = 1'b0;
                     w_state_nxt  = S_TX_ACK;
                  end
               end
            end
            S_TX_ACK: begin
               if (w_scl_rise) begin
                  if (r_sda_s2) begin
                     w_nak_set   = 1'b1;
                     w_state_nxt = S_IGNORE;
                  end else begin
                     w_state_nxt   = S_TX;
                     w_tx_load_nxt = 1'b1;
                  end
               end
            end
            S_IDLE, S_IGNORE: begin
               w_state_nxt = r_state;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase

         // Byte load puts the MSB on SDA in the same SCL low phase
         if (w_tx_req) begin
`ifdef I2C_SLAVE_CLKSTRETCH_EN
            if (r_tx_empty) begin
               w_scl_oe_nxt  = 1'b1;
               w_tx_load_nxt = 1'b1;
            end else begin
               w_sda_oe_nxt   = ~r_tx_data[7];
               w_shift_nxt    = {r_tx_data[6:0], 1'b1};
               w_bit_cnt_nxt  = 3'd7;
               w_tx_empty_set = 1'b1;
               w_tx_load_nxt  = 1'b0;
               w_scl_oe_nxt   = 1'b0;
            end
`else
            w_sda_oe_nxt   = ~w_tx_byte[7];
            w_shift_nxt    = {w_tx_byte[6:0], 1'b1};
            w_bit_cnt_nxt  = 3'd7;
            w_tx_empty_set = 1'b1;
            w_tx_load_nxt  = 1'b0;
`endif
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_bit_cnt  <= 3'd7;
         r_shift    <= 8'h00;
         r_rw       <= 1'b0;
         r_phase    <= 1'b0;
         r_ack_byte <= 1'b0;
         r_tx_load  <= 1'b0;
         r_rx_pend  <= 1'b0;
         r_sda_oe   <= 1'b0;
         r_scl_oe   <= 1'b0;
         r_rx_data  <= 8'h00;
      end else begin
         r_state    <= w_state_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_rw       <= w_rw_nxt;
         r_phase    <= w_phase_nxt;
         r_ack_byte <= w_ack_byte_nxt;
         r_tx_load  <= w_tx_load_nxt;
         r_rx_pend  <= w_rx_pend_nxt;
         r_sda_oe   <= w_sda_oe_nxt;
         r_scl_oe   <= w_scl_oe_nxt;
         r_rx_data  <= w_rx_data_nxt;
      end
   end

   // Protocol sets take priority over CPU clears landing in the same cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_tx_data  <= 8'hFF;
         r_rx_full  <= 1'b0;
         r_tx_empty <= 1'b1;
         r_overrun  <= 1'b0;
         r_nak_rx   <= 1'b0;
         r_busy     <= 1'b0;
         r_ack      <= 1'b0;
         r_dat      <= 32'h0;
      end else begin
         if (w_wr0) r_tx_data <= dat_i[7:0];
         r_rx_full  <= w_rx_full_set  | (r_rx_full  & ~w_rd0);
         r_tx_empty <= w_tx_empty_set | (r_tx_empty & ~w_wr0);
         r_overrun  <= w_overrun_set  | (r_overrun  & ~(w_wr1 & dat_i[3]));
         r_nak_rx   <= w_nak_set      | (r_nak_rx   & ~(w_wr1 & dat_i[4]));
         r_busy     <= w_busy_set     | (r_busy     & ~w_stop);
         r_ack      <= w_req;
         if (w_req && !we_i) r_dat <= w_rd_data;
      end
   end

   assign dat_o  = r_dat;
   assign ack_o  = r_ack;
   assign sda_oe = r_sda_oe;
`ifdef I2C_SLAVE_CLKSTRETCH_EN
   assign scl_oe = r_scl_oe;
`else
   assign scl_oe = 1'b0;
`endif

   assign w_unused = ^{sel_i[3:1], dat_i[31:8], w_tx_byte};

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave
// Brief    : Self-checking bench for i2c_slave: bit-banged master plus CPU bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave;

   localparam int Q = 10;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
   logic [1:0]  adr_i = 2'd0;
   logic [3:0]  sel_i = 4'h0;
   logic [31:0] dat_i = 32'h0;
   logic [31:0] dat_o;
   logic        ack_o, sda_oe, scl_oe;
   logic        m_scl = 1'b1, m_sda = 1'b1;
   wire         scl_line, sda_line;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          sda_hits = 0;
   logic [31:0] exp_q[$];

   assign scl_line = m_scl & ~scl_oe;
   assign sda_line = m_sda & ~sda_oe;

   i2c_slave #(.SLAVE_ADDR(7'h42)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i), .sel_i(sel_i),
      .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
      .scl_i(scl_line), .sda_i(sda_line), .sda_oe(sda_oe), .scl_oe(scl_oe)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) if (sda_oe) sda_hits <= sda_hits + 1;

   task automatic qwait();
      repeat (Q) @(negedge clk_i);
   endtask

   task automatic scl_release();
      int n = 0;
      m_scl = 1'b1;
      while (scl_line !== 1'b1 && n < 2000) begin @(negedge clk_i); n++; end
      if (scl_line !== 1'b1) begin
         n_checks++; n_fail++;
         $display("FAIL scl_release_timeout got=%b want=1", scl_line);
      end
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; qwait(); scl_release(); qwait();
      m_sda = 1'b0; qwait(); m_scl = 1'b0; qwait();
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; qwait(); scl_release(); qwait();
      m_sda = 1'b1; qwait();
   endtask

   task automatic write_bit(input logic b);
      m_sda = b; qwait(); scl_release(); qwait(); qwait();
      m_scl = 1'b0; qwait();
   endtask

   task automatic read_bit(output logic b);
      m_sda = 1'b1; qwait(); scl_release(); qwait();
      b = sda_line; qwait();
      m_scl = 1'b0; qwait();
   endtask

   task automatic i2c_write_byte(input logic [7:0] v, output logic a);
      for (int i = 7; i >= 0; i--) write_bit(v[i]);
      read_bit(a);
   endtask

   task automatic i2c_read_byte(input logic nak, output logic [7:0] v);
      logic b;
      for (int i = 7; i >= 0; i--) begin read_bit(b); v[i] = b; end
      write_bit(nak);
   endtask

   task automatic bus_access(input logic w, input logic [1:0] a, input logic [31:0] wd,
                             output logic [31:0] rd);
      int n = 0;
      @(negedge clk_i);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; sel_i = 4'hF; dat_i = wd;
      do begin @(negedge clk_i); n++; end while (ack_o !== 1'b1 && n < 16);
      rd = dat_o;
      if (ack_o !== 1'b1) begin
         n_checks++; n_fail++;
         $display("FAIL bus_ack_timeout got=%b want=1", ack_o);
      end
      cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d, e;
      rst_i = 1'b1;
      repeat (4) @(negedge clk_i);
      n_checks++; if (ack_o !== 1'b0)     begin n_fail++; $display("FAIL reset_ack got=%b want=0", ack_o); end
      n_checks++; if (dat_o !== 32'h0)    begin n_fail++; $display("FAIL reset_dat got=%h want=0", dat_o); end
      n_checks++; if (sda_oe !== 1'b0)    begin n_fail++; $display("FAIL reset_sda_oe got=%b want=0", sda_oe); end
      n_checks++; if (scl_oe !== 1'b0)    begin n_fail++; $display("FAIL reset_scl_oe got=%b want=0", scl_oe); end
      rst_i = 1'b0;
      repeat (3) @(negedge clk_i);
      exp_q.push_back(32'h02); bus_access(1'b0, 2'd1, 32'h0, d); e = exp_q.pop_front();
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL reset_status got=%h want=%h", d, e); end
      exp_q.push_back(32'h00); bus_access(1'b0, 2'd0, 32'h0, d); e = exp_q.pop_front();
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL reset_rx_data got=%h want=%h", d, e); end
      bus_access(1'b1, 2'd2, 32'hFFFF_FFFF, d);
      exp_q.push_back(32'h00); bus_access(1'b0, 2'd2, 32'h0, d); e = exp_q.pop_front();
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL reg2_zero got=%h want=%h", d, e); end
   endtask

   task automatic test_write();
      logic a0, a1;
      logic [31:0] d, e;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
      i2c_start(); i2c_write_byte(8'h84, a0); i2c_write_byte(8'hA5, a1); i2c_stop();
      e = exp_q.pop_front();
      n_checks++; if ({31'h0, a0} !== e) begin n_fail++; $display("FAIL wr_addr_ack got=%b want=%h", a0, e); end
      e = exp_q.pop_front();
      n_checks++; if ({31'h0, a1} !== e) begin n_fail++; $display("FAIL wr_data_ack got=%b want=%h", a1, e); end
      exp_q.push_back(32'h03); bus_access(1'b0, 2'd1, 32'h0, d); e = exp_q.pop_front();
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL wr_status got=%h want=%h", d, e); end
      exp_q.push_back(32'hA5); bus_access(1'b0, 2'd0, 32'h0, d); e = exp_q.pop_front();
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL wr_rx_data got=%h want=%h", d, e); end
      exp_q.push_back(32'h02); bus_access(1'b0, 2'd1, 32'h0, d); e = exp_q.pop_front();
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL wr_status_after_read got=%h want=%h", d, e); end
   endtask

   task automatic test_wrong_addr();
      logic a;
      logic [31:0] d, e;
      int hits0;
      hits0 = sda_hits;
      exp_q.push_back(32'h1);
      i2c_start(); i2c_write_byte(8'h86, a);
      e = exp_q.pop_front();
      n_checks++; if ({31'h0, a} !== e) begin n_fail++; $display("FAIL wa_addr_nak got=%b want=%h", a, e); end
      exp_q.push_back(32'h02); bus_access(1'b0, 2'd1, 32'h0, d); e = exp_q.pop_front();
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL wa_busy got=%h want=%h", d, e); end
      i2c_stop();
      n_checks++; if (sda_hits !== hits0) begin n_fail++; $display("FAIL wa_sda_quiet got=%0d want=%0d", sda_hits, hits0); end
   endtask

   task automatic test_read();
      logic a;
      logic [7:0] v;
      logic [31:0] d, e;
      bus_access(1'b1, 2'd0, 32'h0000_003C, d);
      exp_q.push_back(32'h00); bus_access(1'b0, 2'd1, 32'h0, d); e = exp_q.pop_front();
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL rd_tx_loaded got=%h want=%h", d, e); end
      exp_q.push_back(32'h0); exp_q.push_back(32'h3C);
      i2c_start(); i2c_write_byte(8'h85, a); i2c_read_byte(1'b1, v); i2c_stop();
      e = exp_q.pop_front();
      n_checks++; if ({31'h0, a} !== e) begin n_fail++; $display("FAIL rd_addr_ack got=%b want=%h", a, e); end
      e = exp_q.pop_front();
      n_checks++; if ({24'h0, v} !== e) begin n_fail++; $display("FAIL rd_sda_byte got=%h want=%h", v, e); end
      exp_q.push_back(32'h12); bus_access(1'b0, 2'd1, 32'h0, d); e = exp_q.pop_front();
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL rd_status got=%h want=%h", d, e); end
      bus_access(1'b1, 2'd1, 32'h10, d);
      exp_q.push_back(32'h02); bus_access(1'b0, 2'd1, 32'h0, d); e = exp_q.pop_front();
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL rd_nak_clear got=%h want=%h", d, e); end
   endtask

   task automatic test_overrun();
      logic a0, a1, a2;
      logic [31:0] d, e;
      exp_q.push_back(32'h0); exp_q.push_back(32'h0);
`ifdef I2C_SLAVE_CLKSTRETCH_EN
      exp_q.push_back(32'h0);
`else
      exp_q.push_back(32'h1);
`endif
      i2c_start(); i2c_write_byte(8'h84, a0); i2c_write_byte(8'h11, a1);
`ifdef I2C_SLAVE_CLKSTRETCH_EN
      fork
         i2c_write_byte(8'h22, a2);
         begin
            int n = 0;
            logic [31:0] sd, se;
            while (scl_oe !== 1'b1 && n < 2000) begin @(negedge clk_i); n++; end
            n_checks++; if (scl_oe !== 1'b1) begin n_fail++; $display("FAIL ov_stretch got=%b want=1", scl_oe); end
            exp_q.push_back(32'h11); bus_access(1'b0, 2'd0, 32'h0, sd); se = exp_q.pop_back();
            n_checks++; if (sd !== se) begin n_fail++; $display("FAIL ov_stretch_read got=%h want=%h", sd, se); end
         end
      join
`else
      i2c_write_byte(8'h22, a2);
`endif
      i2c_stop();
      e = exp_q.pop_front();
      n_checks++; if ({31'h0, a0} !== e) begin n_fail++; $display("FAIL ov_addr_ack got=%b want=%h", a0, e); end
      e = exp_q.pop_front();
      n_checks++; if ({31'h0, a1} !== e) begin n_fail++; $display("FAIL ov_first_ack got=%b want=%h", a1, e); end
      e = exp_q.pop_front();
      n_checks++; if ({31'h0, a2} !== e) begin n_fail++; $display("FAIL ov_second_ack got=%b want=%h", a2, e); end
`ifdef I2C_SLAVE_CLKSTRETCH_EN
      exp_q.push_back(32'h03); exp_q.push_back(32'h22);
`else
      exp_q.push_back(32'h0B); exp_q.push_back(32'h11);
`endif
      bus_access(1'b0, 2'd1, 32'h0, d); e = exp_q.pop_front();
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL ov_status got=%h want=%h", d, e); end
      bus_access(1'b0, 2'd0, 32'h0, d); e = exp_q.pop_front();
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL ov_rx_data got=%h want=%h", d, e); end
      bus_access(1'b1, 2'd1, 32'h08, d);
      exp_q.push_back(32'h02); bus_access(1'b0, 2'd1, 32'h0, d); e = exp_q.pop_front();
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL ov_clear got=%h want=%h", d, e); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      @(negedge clk_i);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 2'd1; sel_i = 4'hF;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back((i % 2 == 0) ? 32'h1 : 32'h0);
         @(negedge clk_i);
         e = exp_q.pop_front();
         n_checks++; if ({31'h0, ack_o} !== e) begin n_fail++; $display("FAIL b2b_ack[%0d] got=%b want=%h", i, ack_o, e); end
         if (ack_o === 1'b1) begin
            n_checks++; if (dat_o !== 32'h02) begin n_fail++; $display("FAIL b2b_data[%0d] got=%h want=02", i, dat_o); end
         end
      end
      cyc_i = 1'b0; stb_i = 1'b0;
   endtask

   task automatic test_repeated_start();
      logic a0, a1, a2;
      logic [7:0] v;
      logic [31:0] d, e;
      bus_access(1'b1, 2'd0, 32'h5A, d);
      exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h5A);
      i2c_start(); i2c_write_byte(8'h84, a0); i2c_write_byte(8'h77, a1);
      i2c_start(); i2c_write_byte(8'h85, a2);
      bus_access(1'b1, 2'd0, 32'h0F, d);
      i2c_read_byte(1'b0, v);
      e = exp_q.pop_front();
      n_checks++; if ({31'h0, a0} !== e) begin n_fail++; $display("FAIL rs_wr_addr_ack got=%b want=%h", a0, e); end
      e = exp_q.pop_front();
      n_checks++; if ({31'h0, a1} !== e) begin n_fail++; $display("FAIL rs_wr_data_ack got=%b want=%h", a1, e); end
      e = exp_q.pop_front();
      n_checks++; if ({31'h0, a2} !== e) begin n_fail++; $display("FAIL rs_rd_addr_ack got=%b want=%h", a2, e); end
      e = exp_q.pop_front();
      n_checks++; if ({24'h0, v} !== e) begin n_fail++; $display("FAIL rs_tx_byte got=%h want=%h", v, e); end
      // next byte 0x0F starts with a 0, so SDA must be pulled low now
      n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rs_tx_msb got=%b want=1", sda_oe); end
      @(posedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rs_reset_release got=%b want=0", sda_oe); end
      n_checks++; if (dut.r_state !== 3'd0) begin n_fail++; $display("FAIL rs_reset_state got=%0d want=0", dut.r_state); end
      @(negedge clk_i);
      rst_i = 1'b0;
      m_scl = 1'b1; qwait(); m_sda = 1'b1; qwait();
      exp_q.push_back(32'h02); bus_access(1'b0, 2'd1, 32'h0, d); e = exp_q.pop_front();
      n_checks++; if (d !== e) begin n_fail++; $display("FAIL rs_status_after_reset got=%h want=%h", d, e); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_wrong_addr();
      test_read();
      test_overrun();
      test_back_to_back();
      test_repeated_start();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h42, 7-bit address the block responds to.
REQ-002 SHALL have clk_i input 1 system clock; rst_i input 1 reset, asynchronous, active-high.
REQ-003 SHALL have bus ports: cyc_i in 1, stb_i in 1, we_i in 1, adr_i in 2, sel_i in 4, dat_i in 32, dat_o out 32, ack_o out 1 (cycle done).
REQ-004 SHALL have scl_i in 1 (bus clock sense), sda_i in 1 (bus data sense), sda_oe out 1 (1 = pull SDA low, open-drain).
REQ-005 SHALL have scl_oe out 1 (1 = pull SCL low), tied 0 unless I2C_SLAVE_CLKSTRETCH_EN is defined.

Function
REQ-006 SHALL pass scl_i/sda_i through 2-flop synchronizers and detect edges on the synchronized copies; all protocol decisions use synchronized values only.
REQ-007 SHALL detect START as SDA falling while SCL high, and STOP as SDA rising while SCL high; both are valid in every state.
REQ-008 START (including repeated START) SHALL force state ADDR, bit counter 7, and clear the shift register.
REQ-009 STOP SHALL force IDLE, release sda_oe and scl_oe, and clear busy.
REQ-010 States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, IGNORE.
REQ-011 ADDR: shift SDA in MSB-first on each SCL rising edge; after 8 bits, if bits[7:1]==SLAVE_ADDR go to ADDR_ACK with rw=bit0, else go to IGNORE.
REQ-012 ADDR_ACK: assert sda_oe on the SCL falling edge after bit 8 and hold for one SCL high period; release on the next falling edge; set busy; go to TX if rw=1, else RX.
REQ-013 RX: receive 8 bits MSB-first on SCL rising edges; on the 8th, if rx_full=0, load rx_data, set rx_full, and ACK (RX_ACK drives SDA low); if rx_full=1, set overrun, discard the byte, and NAK (SDA released).
REQ-014 TX: on each SCL falling edge, drive sda_oe = ~tx_shift[7] and shift; load tx_shift from tx_data on entry and set tx_empty; if tx_empty was already 1, send 8'hFF.
REQ-015 TX_ACK: release SDA and sample master ACK on the SCL rising edge; ACK (0) goes to TX, NAK (1) sets nak_rx and goes to IGNORE.
REQ-016 IGNORE: never drive SDA or SCL; wait for START or STOP.
REQ-017 Bus register 0: read returns {24'h0, rx_data} and clears rx_full; write with sel_i[0] loads tx_data from dat_i[7:0] and clears tx_empty.
REQ-018 Bus register 1: read returns {27'h0, nak_rx, overrun, busy, tx_empty, rx_full}; write with sel_i[0] clears overrun if dat_i[3]=1 and nak_rx if dat_i[4]=1.
REQ-019 Bus registers 2 and 3: reads return 0; writes are ignored.
REQ-020 ack_o SHALL assert exactly one cycle, the cycle after cyc_i&stb_i is sampled; back-to-back requests complete every second cycle.
REQ-021 If a bus access and a protocol event update the same flag in the same cycle, the protocol set SHALL win over the bus clear.

Reset
REQ-022 Reset SHALL give: state IDLE, sda_oe=0, scl_oe=0, ack_o=0, dat_o=0, rx_data=0, tx_data=8'hFF, rx_full=0, tx_empty=1, overrun=0, nak_rx=0, busy=0, synchronizers=1.
REQ-023 Reset asserted mid-transfer SHALL release both bus lines immediately (asynchronously).

Configuration
REQ-024 Macro I2C_SLAVE_CLKSTRETCH_EN: when defined, the block SHALL hold scl_oe=1 after the SCL falling edge that ends an RX byte while rx_full=1, or before TX while tx_empty=1, until the CPU reads or writes register 0; no overrun or 8'hFF substitution occurs.
REQ-025 When I2C_SLAVE_CLKSTRETCH_EN is undefined, scl_oe SHALL be constant 0 and REQ-013/REQ-014 overflow rules apply.

Verification
REQ-026 Master writes addr 0x42/W, byte 0xA5 -> two ACKs, reg1 reads 0x03, reg0 reads 0xA5, then reg1 reads 0x02.
REQ-027 Master addresses 0x43 -> NAK on address, sda_oe never asserted, busy stays 0.
REQ-028 CPU writes 0x3C to reg0; master reads from 0x42 with a NAK after the byte -> SDA carries 0x3C, nak_rx=1, tx_empty=1.
REQ-029 Two write bytes sent without a CPU read -> second byte NAKed, overrun=1, reg0 still shows the first byte; writing reg1 with 0x08 clears overrun. With CLKSTRETCH_EN: SCL held low until reg0 is read, second byte ACKed.
REQ-030 Repeated START after a write phase switches to a read of the same address -> correct ACK and TX data; rst_i pulsed during the TX byte -> sda_oe=0 in the same cycle, state IDLE.
